// File: rtl/cv32e40p_fifo_pkg.sv
// Shared helpers for the multi-pop FIFO: modulo pointer arithmetic and
// derived width calculations.
package cv32e40p_fifo_pkg;

    // Valid for ptr < depth and k <= depth, so one conditional subtract is enough.
    function automatic int unsigned ptr_add(input int unsigned ptr, input int unsigned k,
                                            input int unsigned depth);
        int unsigned sum;
        sum = ptr + k;
        if (sum >= depth) sum = sum - depth;
        return sum;
    endfunction

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned pcnt_w(input int unsigned ports);
        return $clog2(ports + 1);
    endfunction

endpackage

// File: rtl/cv32e40p_fifo_rd_window.sv
// Combinational read window: slot k presents the k-th oldest entry, with the
// incoming push bypassed into the first empty slot in fall-through mode.
module cv32e40p_fifo_rd_window
    import cv32e40p_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned POP_PORTS  = 2,
    parameter int unsigned ADDR_DEPTH = addr_w(DEPTH)
) (
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0]     mem_i,
    input  logic [ADDR_DEPTH-1:0]                rd_ptr_i,
    input  logic [ADDR_DEPTH:0]                  cnt_i,
    input  logic                                 push_ft_i,
    input  logic [DATA_WIDTH-1:0]                data_i,
    output logic [POP_PORTS-1:0][DATA_WIDTH-1:0] data_o,
    output logic [POP_PORTS-1:0]                 valid_o
);

    for (genvar k = 0; k < POP_PORTS; k++) begin : gen_slot
        localparam int unsigned K = k;
        logic [ADDR_DEPTH-1:0] idx;

        assign idx        = ADDR_DEPTH'(ptr_add(32'(rd_ptr_i), K, DEPTH));
        assign valid_o[k] = (32'(cnt_i) + 32'(push_ft_i)) > K;
        assign data_o[k]  = (push_ft_i && (32'(cnt_i) == K)) ? data_i : mem_i[idx];
    end

endmodule

// File: rtl/cv32e40p_fifo_mp.sv
// Multi-pop FIFO: one push per cycle, up to POP_PORTS pops per cycle, any DEPTH,
// almost-full watermark and sticky overflow/underflow flags.
module cv32e40p_fifo_mp
    import cv32e40p_fifo_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned POP_PORTS    = 2,
    parameter int unsigned AFULL_TH     = DEPTH - 1,
    parameter int unsigned ADDR_DEPTH   = addr_w(DEPTH),
    parameter int unsigned PCNT_W       = pcnt_w(POP_PORTS)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic                                 flush_but_first_i,
    input  logic                                 clr_err_i,
    input  logic                                 push_i,
    input  logic [DATA_WIDTH-1:0]                data_i,
    output logic                                 full_o,
    output logic                                 afull_o,
    output logic                                 empty_o,
    output logic [ADDR_DEPTH:0]                  cnt_o,
    output logic [POP_PORTS-1:0][DATA_WIDTH-1:0] data_o,
    output logic [POP_PORTS-1:0]                 valid_o,
    input  logic [PCNT_W-1:0]                    pop_cnt_i,
    output logic                                 ovf_o,
    output logic                                 udf_o
);

    localparam int unsigned CW = ADDR_DEPTH + 1;

    logic [ADDR_DEPTH-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]                    cnt_q, cnt_d, eff, pop_acc;
    logic                             ovf_q, ovf_d, udf_q, udf_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic                             push_acc, push_ft, pop_over, flush_all;

    assign full_o    = (32'(cnt_q) == DEPTH);
    assign afull_o   = (32'(cnt_q) >= AFULL_TH);
    assign push_acc  = push_i & ~full_o;
    assign push_ft   = FALL_THROUGH & push_acc;
    assign eff       = cnt_q + CW'(push_ft);
    assign pop_over  = 32'(pop_cnt_i) > 32'(eff);
    assign pop_acc   = pop_over ? eff : CW'(pop_cnt_i);
    assign flush_all = flush_i | (flush_but_first_i & (cnt_q == '0));

    assign cnt_o   = cnt_q;
    assign empty_o = ~valid_o[0];
    assign ovf_o   = ovf_q;
    assign udf_o   = udf_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q & ~clr_err_i;
        udf_d    = udf_q & ~clr_err_i;
        if (flush_all) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else if (flush_but_first_i) begin
            wr_ptr_d = ADDR_DEPTH'(ptr_add(32'(rd_ptr_q), 1, DEPTH));
            cnt_d    = CW'(1);
        end else begin
            // A full FIFO drops the push even if a pop frees a slot this cycle.
            rd_ptr_d = ADDR_DEPTH'(ptr_add(32'(rd_ptr_q), 32'(pop_acc), DEPTH));
            wr_ptr_d = ADDR_DEPTH'(ptr_add(32'(wr_ptr_q), 32'(push_acc), DEPTH));
            cnt_d    = cnt_q + CW'(push_acc) - pop_acc;
            ovf_d    = ovf_d | (push_i & full_o);
            udf_d    = udf_d | pop_over;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && !flush_but_first_i && push_acc) mem_q[wr_ptr_q] <= data_i;
    end

    cv32e40p_fifo_rd_window #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .POP_PORTS  (POP_PORTS),
        .ADDR_DEPTH (ADDR_DEPTH)
    ) u_rd_window (
        .mem_i     (mem_q),
        .rd_ptr_i  (rd_ptr_q),
        .cnt_i     (cnt_q),
        .push_ft_i (push_ft),
        .data_i    (data_i),
        .data_o    (data_o),
        .valid_o   (valid_o)
    );

endmodule

// File: tb/tb_cv32e40p_fifo_mp.sv
// Bench for cv32e40p_fifo_mp: vector table with a data scoreboard on a DEPTH=3
// registered FIFO, plus a hand sequence on a fall-through instance.
module tb_cv32e40p_fifo_mp;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_rst = 0, a_fl = 0, a_fbf = 0, a_clr = 0, a_push = 0;
    logic [DW-1:0] a_d = '0;
    logic [1:0]    a_pop = '0;
    logic          a_full, a_afull, a_empty, a_ovf, a_udf;
    logic [2:0]    a_cnt;
    logic [1:0][DW-1:0] a_do;
    logic [1:0]    a_vld;

    logic          b_rst = 0, b_fl = 0, b_fbf = 0, b_clr = 0, b_push = 0;
    logic [DW-1:0] b_d = '0;
    logic [1:0]    b_pop = '0;
    logic          b_full, b_afull, b_empty, b_ovf, b_udf;
    logic [2:0]    b_cnt;
    logic [1:0][DW-1:0] b_do;
    logic [1:0]    b_vld;

    cv32e40p_fifo_mp #(.FALL_THROUGH(1'b0), .DATA_WIDTH(DW), .DEPTH(3), .POP_PORTS(2)) u_dut (
        .clk_i(clk), .rst_i(a_rst), .flush_i(a_fl), .flush_but_first_i(a_fbf),
        .clr_err_i(a_clr), .push_i(a_push), .data_i(a_d), .full_o(a_full),
        .afull_o(a_afull), .empty_o(a_empty), .cnt_o(a_cnt), .data_o(a_do),
        .valid_o(a_vld), .pop_cnt_i(a_pop), .ovf_o(a_ovf), .udf_o(a_udf));

    cv32e40p_fifo_mp #(.FALL_THROUGH(1'b1), .DATA_WIDTH(DW), .DEPTH(3), .POP_PORTS(2)) u_ft (
        .clk_i(clk), .rst_i(b_rst), .flush_i(b_fl), .flush_but_first_i(b_fbf),
        .clr_err_i(b_clr), .push_i(b_push), .data_i(b_d), .full_o(b_full),
        .afull_o(b_afull), .empty_o(b_empty), .cnt_o(b_cnt), .data_o(b_do),
        .valid_o(b_vld), .pop_cnt_i(b_pop), .ovf_o(b_ovf), .udf_o(b_udf));

    typedef struct {
        logic          rst, fl, fbf, clr, push;
        logic [DW-1:0] d;
        logic [1:0]    pop;
        logic [2:0]    cnt;
        logic          full, afull, empty;
        logic [1:0]    vld;
        logic          ovf, udf;
    } vec_t;

    vec_t          tv[$];
    logic [DW-1:0] sb[$];
    int            checks = 0;
    int            errors = 0;

    function automatic vec_t v(logic rst, logic fl, logic fbf, logic clr, logic push,
                               logic [DW-1:0] d, logic [1:0] pop, logic [2:0] cnt,
                               logic full, logic afull, logic empty, logic [1:0] vld,
                               logic ovf, logic udf);
        vec_t r;
        r.rst = rst; r.fl = fl; r.fbf = fbf; r.clr = clr; r.push = push; r.d = d; r.pop = pop;
        r.cnt = cnt; r.full = full; r.afull = afull; r.empty = empty; r.vld = vld;
        r.ovf = ovf; r.udf = udf;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        //            rst fl fbf clr push d     pop cnt full af  emp vld   ovf udf
        tv.push_back(v(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 2'b00, 0, 0)); // 0 reset
        tv.push_back(v(0, 0, 0, 0, 1, 8'hA1, 0, 1, 0, 0, 0, 2'b01, 0, 0)); // 1 fill
        tv.push_back(v(0, 0, 0, 0, 1, 8'hB2, 0, 2, 0, 1, 0, 2'b11, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 1, 8'hC3, 0, 3, 1, 1, 0, 2'b11, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 2, 1, 0, 0, 0, 2'b01, 0, 0)); // 4 pop 2
        tv.push_back(v(0, 0, 0, 0, 1, 8'hD4, 0, 2, 0, 1, 0, 2'b11, 0, 0)); // 5 wrap
        tv.push_back(v(0, 0, 0, 0, 1, 8'hE5, 0, 3, 1, 1, 0, 2'b11, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 1, 2, 0, 1, 0, 2'b11, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 2'b01, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 2'b00, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 1, 8'hF6, 0, 1, 0, 0, 0, 2'b01, 0, 0)); // 10 overflow
        tv.push_back(v(0, 0, 0, 0, 1, 8'h07, 0, 2, 0, 1, 0, 2'b11, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 1, 8'h08, 0, 3, 1, 1, 0, 2'b11, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 1, 8'h09, 1, 2, 0, 1, 0, 2'b11, 1, 0));
        tv.push_back(v(0, 0, 0, 1, 0, 8'h00, 0, 2, 0, 1, 0, 2'b11, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 2'b01, 0, 0)); // 15 underflow
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 2, 0, 0, 0, 1, 2'b00, 0, 1));
        tv.push_back(v(0, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 2'b00, 0, 1)); // set beats clear
        tv.push_back(v(0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 1, 2'b00, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 1, 8'h1A, 0, 1, 0, 0, 0, 2'b01, 0, 0)); // 19 flush-but-first
        tv.push_back(v(0, 0, 0, 0, 1, 8'h1B, 0, 2, 0, 1, 0, 2'b11, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 1, 8'h1C, 0, 3, 1, 1, 0, 2'b11, 0, 0));
        tv.push_back(v(0, 0, 1, 0, 1, 8'h1D, 1, 1, 0, 0, 0, 2'b01, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 1, 8'h1E, 0, 2, 0, 1, 0, 2'b11, 0, 0));
        tv.push_back(v(1, 1, 0, 0, 1, 8'h1F, 1, 0, 0, 0, 1, 2'b00, 0, 0)); // 24 rst dominates
        tv.push_back(v(0, 0, 0, 0, 1, 8'h20, 0, 1, 0, 0, 0, 2'b01, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 1, 8'h21, 0, 2, 0, 1, 0, 2'b11, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 1, 8'h22, 0, 3, 1, 1, 0, 2'b11, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 1, 8'h23, 0, 3, 1, 1, 0, 2'b11, 1, 0));
        tv.push_back(v(0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 2'b00, 1, 0)); // flush keeps ovf
        tv.push_back(v(0, 0, 1, 0, 1, 8'h24, 1, 0, 0, 0, 1, 2'b00, 1, 0)); // fbf on empty
        tv.push_back(v(0, 0, 0, 0, 1, 8'h25, 0, 1, 0, 0, 0, 2'b01, 1, 0));
        tv.push_back(v(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 2'b00, 0, 0));

        @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            int n;
            bit acc;
            a_rst = tv[i].rst; a_fl = tv[i].fl; a_fbf = tv[i].fbf; a_clr = tv[i].clr;
            a_push = tv[i].push; a_d = tv[i].d; a_pop = tv[i].pop;
            #1;
            for (int k = 0; k < 2; k++)
                if (k < sb.size()) chk($sformatf("window%0d", k), i, 32'(a_do[k]), 32'(sb[k]));
            @(posedge clk);
            if (tv[i].rst || tv[i].fl) sb.delete();
            else if (tv[i].fbf) begin
                while (sb.size() > 1) void'(sb.pop_back());
            end else begin
                acc = tv[i].push && (sb.size() < 3);
                n = (int'(tv[i].pop) < sb.size()) ? int'(tv[i].pop) : sb.size();
                repeat (n) void'(sb.pop_front());
                if (acc) sb.push_back(tv[i].d);
            end
            @(negedge clk);
            chk("cnt",   i, 32'(a_cnt),   32'(tv[i].cnt));
            chk("full",  i, 32'(a_full),  32'(tv[i].full));
            chk("afull", i, 32'(a_afull), 32'(tv[i].afull));
            chk("empty", i, 32'(a_empty), 32'(tv[i].empty));
            chk("valid", i, 32'(a_vld),   32'(tv[i].vld));
            chk("ovf",   i, 32'(a_ovf),   32'(tv[i].ovf));
            chk("udf",   i, 32'(a_udf),   32'(tv[i].udf));
        end
        a_rst = 0; a_push = 0; a_pop = 0; a_fl = 0; a_fbf = 0; a_clr = 0;

        // Fall-through instance: bypass into the window in the push cycle.
        b_rst = 1;
        @(posedge clk); #1 b_rst = 0;
        @(negedge clk);
        chk("ft_rst_cnt", 0, 32'(b_cnt), 0);
        chk("ft_rst_empty", 0, 32'(b_empty), 1);

        b_push = 1; b_d = 8'h5A; b_pop = 1; #1;
        chk("ft_byp_data", 1, 32'(b_do[0]), 32'h5A);
        chk("ft_byp_valid", 1, 32'(b_vld), 32'b01);
        chk("ft_byp_empty", 1, 32'(b_empty), 0);
        @(posedge clk); #1 b_push = 0; b_pop = 0;
        @(negedge clk);
        chk("ft_pp_cnt", 1, 32'(b_cnt), 0);
        chk("ft_pp_empty", 1, 32'(b_empty), 1);
        chk("ft_pp_udf", 1, 32'(b_udf), 0);

        b_push = 1; b_d = 8'h6B; #1;
        chk("ft_y_data", 2, 32'(b_do[0]), 32'h6B);
        @(posedge clk); #1 b_push = 0;
        @(negedge clk);
        chk("ft_y_cnt", 2, 32'(b_cnt), 1);

        b_push = 1; b_d = 8'h7C; #1;
        chk("ft_z_slot0", 3, 32'(b_do[0]), 32'h6B);
        chk("ft_z_slot1", 3, 32'(b_do[1]), 32'h7C);
        chk("ft_z_valid", 3, 32'(b_vld), 32'b11);
        @(posedge clk); #1 b_push = 0;
        @(negedge clk);
        chk("ft_z_cnt", 3, 32'(b_cnt), 2);

        b_push = 1; b_d = 8'h8D; b_pop = 2; #1;
        chk("ft_w_slot0", 4, 32'(b_do[0]), 32'h6B);
        chk("ft_w_slot1", 4, 32'(b_do[1]), 32'h7C);
        @(posedge clk); #1 b_push = 0; b_pop = 0;
        @(negedge clk);
        chk("ft_w_cnt", 4, 32'(b_cnt), 1);
        chk("ft_w_head", 4, 32'(b_do[0]), 32'h8D);
        chk("ft_w_valid", 4, 32'(b_vld), 32'b01);

        b_pop = 3;
        @(posedge clk); #1 b_pop = 0;
        @(negedge clk);
        chk("ft_clamp_cnt", 5, 32'(b_cnt), 0);
        chk("ft_clamp_udf", 5, 32'(b_udf), 1);
        chk("ft_clamp_empty", 5, 32'(b_empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
